// File: rtl/gear_shift_controller_if.sv
// Signal bundle between the driver controls / physics stage and the gear
// shift controller. The controller is the slave; whoever drives the raw
// controls and consumes the gear code is the master.
interface gear_shift_controller_if;
    logic       tick_1ms;
    logic       engine_on;
    logic       btn_up;
    logic       btn_down;
    logic [7:0] speed;
    logic       is_brake_normal;
    logic       is_brake_hard;
    logic [3:0] current_gear;
    logic       shift_busy;
    logic       shift_reject;
    logic [1:0] reject_code;

    modport master (
        output tick_1ms, engine_on, btn_up, btn_down, speed,
               is_brake_normal, is_brake_hard,
        input  current_gear, shift_busy, shift_reject, reject_code
    );

    modport slave (
        input  tick_1ms, engine_on, btn_up, btn_down, speed,
               is_brake_normal, is_brake_hard,
        output current_gear, shift_busy, shift_reject, reject_code
    );
endinterface

// File: rtl/gear_shift_controller.sv
// Gear shift controller: synchronizes and debounces the up/down buttons,
// applies brake/speed interlocks, and engages a new P-R-N-D gear after a
// timed delay. Refused or aborted shifts raise a one-cycle reject pulse.
module gear_shift_controller #(
    parameter int DEBOUNCE_MS    = 20,
    parameter int SHIFT_DELAY_MS = 300
) (
    input  logic                    clk,
    input  logic                    rst,
    gear_shift_controller_if.slave  bus
);

    localparam int DB_W  = $clog2(DEBOUNCE_MS + 1);
    localparam int DLY_W = $clog2(SHIFT_DELAY_MS + 1);

    typedef enum logic [3:0] {
        GEAR_P = 4'd3,
        GEAR_R = 4'd6,
        GEAR_N = 4'd9,
        GEAR_D = 4'd12
    } gear_e;

    typedef enum logic {
        S_IDLE,
        S_ENGAGE
    } state_e;

    localparam logic [1:0] CODE_NO_BRAKE = 2'd1;
    localparam logic [1:0] CODE_SPEED    = 2'd2;
    localparam logic [1:0] CODE_BUSY     = 2'd3;

    // Bit 0 = up button, bit 1 = down button throughout the input path.
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            level_q, level_d, level_prev_q;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic                  up_ev, dn_ev;

    state_e                state_q, state_d;
    gear_e                 target_q, target_d;
    gear_e                 gear_q, gear_d;
    gear_e                 req_target;
    logic                  req_valid;
    logic [DLY_W-1:0]      dly_q, dly_d;
    logic                  busy_q, busy_d;
    logic                  reject_q, reject_d;
    logic [1:0]            code_q, code_d;

    // One step along P-R-N-D; the ends saturate (callers filter them out).
    function automatic gear_e gear_step(input gear_e g, input logic up);
        case (g)
            GEAR_P:  gear_step = up ? GEAR_R : GEAR_P;
            GEAR_R:  gear_step = up ? GEAR_N : GEAR_P;
            GEAR_N:  gear_step = up ? GEAR_D : GEAR_R;
            GEAR_D:  gear_step = up ? GEAR_D : GEAR_N;
            default: gear_step = GEAR_P;
        endcase
    endfunction

    // Debounce: a level flips only after DEBOUNCE_MS consecutive differing strobes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (bus.tick_1ms) begin
                if (db_cnt_q[i] >= DB_W'(DEBOUNCE_MS - 1)) begin
                    level_d[i]  = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Synchronizer, debounced levels and edge-detect history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            db_cnt_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sync1_q      <= {bus.btn_down, bus.btn_up};
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            db_cnt_q     <= db_cnt_d;
        end
    end

    assign up_ev = level_q[0] & ~level_prev_q[0];
    assign dn_ev = level_q[1] & ~level_prev_q[1];

    // Shift FSM next state: interlocks, engage countdown, abort and engine-off force.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        dly_d      = dly_q;
        gear_d     = gear_q;
        reject_d   = 1'b0;
        code_d     = code_q;
        req_valid  = 1'b0;
        req_target = gear_q;

        if (up_ev && !dn_ev && gear_q != GEAR_D) begin
            req_valid  = 1'b1;
            req_target = gear_step(gear_q, 1'b1);
        end else if (dn_ev && !up_ev && gear_q != GEAR_P) begin
            req_valid  = 1'b1;
            req_target = gear_step(gear_q, 1'b0);
        end

        if (!bus.engine_on) begin
            state_d = S_IDLE;
            gear_d  = GEAR_P;
        end else begin
            if (up_ev && dn_ev) begin
                reject_d = 1'b1;
                code_d   = CODE_BUSY;
            end
            if (state_q == S_ENGAGE) begin
                if (up_ev ^ dn_ev) begin
                    reject_d = 1'b1;
                    code_d   = CODE_BUSY;
                end
                if ((target_q == GEAR_P || target_q == GEAR_R) && bus.speed != 8'd0) begin
                    state_d  = S_IDLE;
                    reject_d = 1'b1;
                    code_d   = CODE_SPEED;
                end else if (bus.tick_1ms) begin
                    if (dly_q <= DLY_W'(1)) begin
                        dly_d   = '0;
                        gear_d  = target_q;
                        state_d = S_IDLE;
                    end else begin
                        dly_d = dly_q - DLY_W'(1);
                    end
                end
            end else if (req_valid) begin
                if (gear_q == GEAR_P && !(bus.is_brake_normal || bus.is_brake_hard)) begin
                    reject_d = 1'b1;
                    code_d   = CODE_NO_BRAKE;
                end else if ((req_target == GEAR_P || req_target == GEAR_R) && bus.speed != 8'd0) begin
                    reject_d = 1'b1;
                    code_d   = CODE_SPEED;
                end else begin
                    state_d  = S_ENGAGE;
                    target_d = req_target;
                    dly_d    = DLY_W'(SHIFT_DELAY_MS);
                end
            end
        end

        busy_d = (state_d == S_ENGAGE);
    end

    // Shift FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            target_q <= GEAR_P;
            dly_q    <= '0;
            gear_q   <= GEAR_P;
            busy_q   <= 1'b0;
            reject_q <= 1'b0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            dly_q    <= dly_d;
            gear_q   <= gear_d;
            busy_q   <= busy_d;
            reject_q <= reject_d;
            code_q   <= code_d;
        end
    end

    assign bus.current_gear = gear_q;
    assign bus.shift_busy   = busy_q;
    assign bus.shift_reject = reject_q;
    assign bus.reject_code  = code_q;

endmodule

// File: tb/tb_gear_shift_controller.sv
// Directed bench for gear_shift_controller. A monitor turns output activity
// (reject pulses, gear changes, busy edges) into an observed event queue;
// each step pushes the events it expects and then drains both queues.
module tb_gear_shift_controller;

    localparam int CLK_PER_MS = 4;

    localparam logic [1:0] EV_REJ  = 2'd0;
    localparam logic [1:0] EV_GEAR = 2'd1;
    localparam logic [1:0] EV_BUSY = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] val;
    } ev_t;

    typedef struct {
        ev_t ev;
        int  tick;
    } obs_t;

    logic clk;
    logic rst;
    gear_shift_controller_if bus ();

    gear_shift_controller #(
        .DEBOUNCE_MS    (20),
        .SHIFT_DELAY_MS (300)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    int   ticks    = 0;
    bit   mon_en   = 1'b0;
    ev_t  exp_q[$];
    obs_t obs_q[$];
    obs_t last_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1 ms strobe: one cycle high every CLK_PER_MS cycles.
    initial begin
        bus.tick_1ms = 1'b0;
        forever begin
            repeat (CLK_PER_MS - 1) @(negedge clk);
            bus.tick_1ms = 1'b1;
            @(negedge clk);
            bus.tick_1ms = 1'b0;
        end
    end

    // Count strobes as the DUT sees them.
    initial forever begin
        @(posedge clk);
        if (bus.tick_1ms) ticks++;
    end

    // Output monitor.
    initial begin
        logic [3:0] prev_gear;
        logic       prev_busy;
        obs_t       o;
        prev_gear = 4'd3;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                o.tick = ticks;
                if (bus.shift_reject === 1'b1) begin
                    o.ev.kind = EV_REJ;
                    o.ev.val  = {2'b00, bus.reject_code};
                    obs_q.push_back(o);
                end
                if (bus.current_gear !== prev_gear) begin
                    o.ev.kind = EV_GEAR;
                    o.ev.val  = bus.current_gear;
                    obs_q.push_back(o);
                end
                if (bus.shift_busy !== prev_busy) begin
                    o.ev.kind = EV_BUSY;
                    o.ev.val  = {3'b000, bus.shift_busy};
                    obs_q.push_back(o);
                end
            end
            prev_gear = bus.current_gear;
            prev_busy = bus.shift_busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic [3:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic wait_ms(input int ms);
        repeat (ms * CLK_PER_MS) @(negedge clk);
    endtask

    // Hold the button(s) well past the debounce window, release, let the release settle.
    task automatic press(input logic up, input logic dn);
        @(negedge clk);
        bus.btn_up   = up;
        bus.btn_down = dn;
        wait_ms(30);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        wait_ms(25);
    endtask

    // Wait (bounded) for the expected event count, then compare in order.
    task automatic drain(input string tag, input int budget);
        int   waited;
        ev_t  e;
        obs_t o;
        waited = 0;
        while (obs_q.size() < exp_q.size() && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        repeat (8) @(negedge clk);
        check({tag, " event count"}, obs_q.size(), exp_q.size());
        last_q.delete();
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, " event"}, {26'd0, o.ev}, {26'd0, e});
            last_q.push_back(o);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic shift_ok(input string tag, input logic up, input logic [3:0] new_gear);
        push_exp(EV_BUSY, 4'd1);
        push_exp(EV_GEAR, new_gear);
        push_exp(EV_BUSY, 4'd0);
        press(up, ~up);
        drain(tag, 2000);
    endtask

    initial begin
        int t0;
        bus.engine_on       = 1'b1;
        bus.btn_up          = 1'b0;
        bus.btn_down        = 1'b0;
        bus.speed           = 8'd0;
        bus.is_brake_normal = 1'b1;
        bus.is_brake_hard   = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset gear",   bus.current_gear, 4'd3);
        check("reset busy",   bus.shift_busy,   1'b0);
        check("reset reject", bus.shift_reject, 1'b0);
        check("reset code",   bus.reject_code,  2'd0);
        mon_en = 1'b1;

        // P -> R with brake; check debounce latency and exact engage length.
        t0 = ticks;
        shift_ok("P to R", 1'b1, 4'd6);
        if (last_q.size() >= 2) begin
            check("press latency in 20..21 ms",
                  ((last_q[0].tick - t0) >= 20 && (last_q[0].tick - t0) <= 21), 1'b1);
            check("engage strobes", last_q[1].tick - last_q[0].tick, 300);
        end else begin
            check("engage events present", last_q.size(), 2);
        end

        // R -> P, then down in P is silently ignored.
        shift_ok("R to P", 1'b0, 4'd3);
        press(1'b0, 1'b1);
        drain("down in P", 200);

        // Leaving P without brake is refused.
        bus.is_brake_normal = 1'b0;
        push_exp(EV_REJ, 4'd1);
        press(1'b1, 1'b0);
        drain("no brake", 200);
        check("code held 1", bus.reject_code, 2'd1);
        check("gear stays P", bus.current_gear, 4'd3);

        // Hard brake alone is enough to leave P.
        bus.is_brake_hard = 1'b1;
        shift_ok("P to R hard brake", 1'b1, 4'd6);
        bus.is_brake_hard   = 1'b0;
        bus.is_brake_normal = 1'b1;
        shift_ok("R to N", 1'b1, 4'd9);

        // Moving: N -> R refused, N -> D and D -> N allowed.
        bus.speed = 8'd40;
        push_exp(EV_REJ, 4'd2);
        press(1'b0, 1'b1);
        drain("N to R moving", 200);
        check("code held 2", bus.reject_code, 2'd2);
        shift_ok("N to D moving", 1'b1, 4'd12);
        shift_ok("D to N moving", 1'b0, 4'd9);

        // N -> R accepted at rest, aborted when the car starts to roll.
        bus.speed = 8'd0;
        push_exp(EV_BUSY, 4'd1);
        push_exp(EV_REJ,  4'd2);
        push_exp(EV_BUSY, 4'd0);
        press(1'b0, 1'b1);
        wait_ms(65);
        bus.speed = 8'd5;
        wait_ms(5);
        bus.speed = 8'd0;
        drain("abort N to R", 2000);
        check("gear after abort", bus.current_gear, 4'd9);

        // 5 ms glitches never pass the debouncer.
        for (int i = 0; i < 3; i++) begin
            bus.btn_up = 1'b1;
            wait_ms(5);
            bus.btn_up = 1'b0;
            wait_ms(5);
        end
        wait_ms(30);
        drain("glitches", 100);

        // Simultaneous up and down.
        push_exp(EV_REJ, 4'd3);
        press(1'b1, 1'b1);
        drain("both buttons", 200);
        check("gear after conflict", bus.current_gear, 4'd9);

        // Second press during engage is refused; the pending shift completes.
        push_exp(EV_BUSY, 4'd1);
        push_exp(EV_REJ,  4'd3);
        push_exp(EV_GEAR, 4'd12);
        push_exp(EV_BUSY, 4'd0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        drain("press while busy", 2000);
        check("code held 3", bus.reject_code, 2'd3);

        // Up in D is silently ignored.
        press(1'b1, 1'b0);
        drain("up in D", 200);

        // Engine off while engaging D -> N forces P next cycle.
        push_exp(EV_BUSY, 4'd1);
        push_exp(EV_GEAR, 4'd3);
        push_exp(EV_BUSY, 4'd0);
        press(1'b0, 1'b1);
        check("busy before engine off", bus.shift_busy, 1'b1);
        bus.engine_on = 1'b0;
        @(negedge clk);
        check("engine off gear", bus.current_gear, 4'd3);
        check("engine off busy", bus.shift_busy, 1'b0);
        wait_ms(10);
        bus.engine_on = 1'b1;
        drain("engine off", 200);

        // Reset mid-engage: outputs return to reset values at once, no reject.
        push_exp(EV_BUSY, 4'd1);
        push_exp(EV_BUSY, 4'd0);
        press(1'b1, 1'b0);
        check("busy before reset", bus.shift_busy, 1'b1);
        rst = 1'b0;
        #1;
        check("mid reset gear",   bus.current_gear, 4'd3);
        check("mid reset busy",   bus.shift_busy,   1'b0);
        check("mid reset reject", bus.shift_reject, 1'b0);
        check("mid reset code",   bus.reject_code,  2'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_ms(300);
        drain("reset mid engage", 200);
        check("gear after reset", bus.current_gear, 4'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gear_shift_controller.md
# gear_shift_controller

Converts the driver's raw gear-up/gear-down buttons into the debounced, interlocked `current_gear` code consumed by the vehicle physics/RPM stage. It sits directly upstream of that stage. It owns the P-R-N-D selector state, brake and speed interlocks, and a timed engage delay. It reports refused shifts to the dashboard through a one-cycle reject pulse with a reason code.

## Interface
- `DEBOUNCE_MS`, 20, consecutive stable `tick_1ms` periods required to accept a button level change
- `SHIFT_DELAY_MS`, 300, `tick_1ms` periods between accepting a shift and driving the new gear
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `tick_1ms`  in  1  one-cycle strobe every 1 ms
- `engine_on`  in  1  engine running
- `btn_up`  in  1  raw, asynchronous gear-up button, high = pressed
- `btn_down`  in  1  raw, asynchronous gear-down button, high = pressed
- `speed`  in  8  current vehicle speed, km/h, from the physics stage
- `is_brake_normal`  in  1  normal brake pressed
- `is_brake_hard`  in  1  hard brake pressed
- `current_gear`  out  4  gear code: 3 = P, 6 = R, 9 = N, 12 = D; no other value is ever driven
- `shift_busy`  out  1  high while an accepted shift is engaging
- `shift_reject`  out  1  one-cycle pulse when a request is refused or aborted
- `reject_code`  out  2  reason, valid with `shift_reject`, held until the next reject: 1 = no brake, 2 = speed not zero, 3 = busy or conflict

## Operation
- **Input path.** Each button passes through a 2-flop synchronizer and then a debouncer.
  - The debouncer holds a stable level. It changes that level only after the synchronized input has differed from it on `DEBOUNCE_MS` consecutive `tick_1ms` strobes.
  - Any sample that matches the held level clears the counter.
  - A rising edge of the debounced level produces a one-cycle press event. Releases produce nothing.
- **Gear order.** P, R, N, D. An up press moves one step right and a down press moves one step left.
  - Up in D and down in P are ignored silently: no reject.
- **Interlocks.** These are evaluated in the press-event cycle against the target gear:
  - leaving P requires `is_brake_normal | is_brake_hard`, otherwise reject code 1;
  - entering P or R requires `speed == 0`, otherwise reject code 2;
  - entering N or D has no speed condition.
- **FSM.** States IDLE and ENGAGE.
  - IDLE to ENGAGE on an accepted press: latch the target, load the delay counter with `SHIFT_DELAY_MS`, raise `shift_busy`.
  - In ENGAGE, each `tick_1ms` decrements the counter. When it reaches 0, `current_gear` takes the target and the FSM returns to IDLE.
  - In ENGAGE, if the target is P or R and `speed` becomes nonzero, abort: `current_gear` is unchanged, reject code 2, return to IDLE.
  - A press event while in ENGAGE is rejected with code 3 and does not disturb the pending shift.
  - Up and down press events in the same cycle: both are discarded, reject code 3, no state change, from either state.
- **Engine off.** While `engine_on` is low, `current_gear` is forced to P, the FSM is held in IDLE, `shift_busy` is 0, and no press events are acted on. Debouncers keep running.
- **Counter widths.** Delay and debounce counters are sized with `$clog2(param+1)`. They saturate at 0 and never wrap.

## Timing
- **Reset values:** `current_gear` = 3, `shift_busy` = 0, `shift_reject` = 0, `reject_code` = 0. FSM in IDLE, debounced levels 0, all counters 0. Reset may assert mid-engage and aborts with no reject pulse.
- **Press-event latency:** 2 cycles of synchronizer, plus `DEBOUNCE_MS` strobes, plus 1 cycle.
- **Accept:** `shift_busy` rises in the cycle after the press event.
- **Gear change:** `current_gear` updates in the cycle after the `SHIFT_DELAY_MS`-th strobe following accept, and `shift_busy` falls in that same cycle.
- **Reject:** `shift_reject` is high for exactly 1 cycle, the cycle after the press event or abort condition. `reject_code` updates in that same cycle.
- **Engine-off force:** takes effect 1 cycle after `engine_on` falls.
- **Same-cycle priority:** engine-off forcing overrides an abort, which overrides completion.

## Test plan
- Reset, engine on, brake held, speed 0; `btn_up` held 25 ms → `shift_busy` high about 20 ms after press; `current_gear` 3→6 exactly 300 strobes later; no reject.
- In P with no brake, `btn_up` pressed → `shift_reject` 1 cycle, `reject_code` = 1, gear stays 3, `shift_busy` never high.
- In N at speed 40, down press (target R) → reject code 2. Then in D at speed 40, down press → gear becomes 9 after 300 ms.
- In N at speed 0, accept a down press to R, then set speed 5 at 100 ms into the engage → abort: reject code 2, gear stays 9, busy falls.
- 5 ms glitches on `btn_up` → no events. Simultaneous up/down presses → reject code 3. Second press during ENGAGE → code 3 and the original shift still completes.
- In D with `shift_busy` high, drop `engine_on` → next cycle gear = 3, busy = 0; assert `rst` low mid-engage → all outputs at reset values immediately.
